// File: rtl/uart_oversample_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_oversample_rx
// Purpose  : UART receiver, 8N1, LSB first, idle-high line. The rx input is
//            oversampled at CLKS_PER_BIT clocks per bit, and each bit is
//            sampled at its midpoint. A good byte appears on data together
//            with a one-cycle recv strobe.
// Option   : UART_RX_PARITY_EN adds an even-parity bit (8E1), a PARITY
//            state and the parity_err port.
// Ports    : clk        - clock, all logic on posedge
//            rst        - asynchronous, active-high reset
//            rx         - serial line, asynchronous to clk, idle = 1
//            data[7:0]  - last correctly received byte
//            recv       - 1-cycle strobe, data updated this cycle
//            frame_err  - 1-cycle strobe, stop bit sampled 0
//            busy       - high whenever the receiver is not idle
//            parity_err - 1-cycle strobe, parity mismatch (option only)
// Revision : 1.0 - initial release
// ============================================================================
module uart_oversample_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       recv,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BRK    = 3'd5
    } state_t;

    logic             rx_meta_q, rx_s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             recv_q, recv_d;
    logic             ferr_q, ferr_d;
    logic             w_bit_end;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    assign w_bit_end = (cnt_q == C_BIT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        recv_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Re-check the line at mid start bit; a short low pulse is
                // dropped silently.
                if (cnt_q == C_HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    shift_d[idx_q] = rx_s_q;
                    cnt_d          = '0;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    par_d   = rx_s_q;
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                // Leaving at mid stop bit leaves half a bit of margin for a
                // start bit that immediately follows.
                if (w_bit_end) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift_q, par_q}) begin
                            perr_d = 1'b1;
                        end else begin
                            data_d = shift_q;
                            recv_d = 1'b1;
                        end
`else
                        data_d = shift_q;
                        recv_d = 1'b1;
`endif
                    end else begin
                        // Framing failure wins over parity; the line must
                        // go high again before a new frame is accepted.
                        ferr_d  = 1'b1;
                        state_d = S_BRK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BRK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            recv_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            recv_q    <= recv_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign data      = data_q;
    assign recv      = recv_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_oversample_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_oversample_rx
// Purpose  : Self-checking bench for uart_oversample_rx. Frames are driven
//            bit by bit on rx; strobes are logged with their cycle stamp and
//            compared with expected bytes and arrival times.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_oversample_rx;

    localparam int CPB  = 16;
    localparam int CPB4 = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif

    // Cycles from the start-bit edge to the recv/error strobe.
    function automatic int latency(input int cpb);
        return 2 + cpb / 2 + (9 + NPAR) * cpb + 1;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rx4 = 1'b1;
    logic [7:0] data, data4;
    logic       recv, recv4, frame_err, ferr4, busy, busy4;
    logic       perr, perr4;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_data = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_oversample_rx #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .recv(recv),
        .frame_err(frame_err), .busy(busy)
`ifdef UART_RX_PARITY_EN
        , .parity_err(perr)
`endif
    );

    uart_oversample_rx #(.CLKS_PER_BIT(CPB4)) u_dut4 (
        .clk(clk), .rst(rst), .rx(rx4), .data(data4), .recv(recv4),
        .frame_err(ferr4), .busy(busy4)
`ifdef UART_RX_PARITY_EN
        , .parity_err(perr4)
`endif
    );

`ifndef UART_RX_PARITY_EN
    assign perr  = 1'b0;
    assign perr4 = 1'b0;
`endif

    typedef struct packed { int t; logic [7:0] d; } ev_t;
    ev_t recv_ev[$];
    ev_t recv4_ev[$];
    int  ferr_ev[$];
    int  perr_ev[$];
    int  other4_n = 0;
    int  viol = 0;
    logic pr = 1'b0, pf = 1'b0, pp = 1'b0;

    always @(negedge clk) begin : mon
        ev_t e;
        e.t = cyc;
        e.d = data;
        if (recv) recv_ev.push_back(e);
        if (frame_err) ferr_ev.push_back(cyc);
        if (perr) perr_ev.push_back(cyc);
        e.d = data4;
        if (recv4) recv4_ev.push_back(e);
        if (ferr4 || perr4) other4_n++;
        if ((int'(recv) + int'(frame_err) + int'(perr)) > 1) viol++;
        if ((recv && pr) || (frame_err && pf) || (perr && pp)) viol++;
        pr = recv; pf = frame_err; pp = perr;
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        recv_ev.delete(); recv4_ev.delete(); ferr_ev.delete(); perr_ev.delete();
    endtask

    // Drives the first nbits of a frame (start, data LSB first, [parity], stop).
    // Must be called aligned (#1 after a posedge); returns aligned as well.
    task automatic send_frame(input bit on4, input logic [7:0] b, input logic pbit,
                              input logic stop, input int nbits, output int t0);
        logic [10:0] bits;
        int n;
        int cpb;
        cpb  = on4 ? CPB4 : CPB;
        n    = 10 + NPAR;
        bits = '1;
        bits[0]   = 1'b0;
        bits[8:1] = b;
        if (NPAR == 1) begin
            bits[9]  = pbit;
            bits[10] = stop;
        end else begin
            bits[9]  = stop;
        end
        if (nbits < n) n = nbits;
        t0 = cyc;
        for (int i = 0; i < n; i++) begin
            if (on4) rx4 = bits[i];
            else     rx  = bits[i];
            tick(cpb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rx4 = 1'b1;
        tick(3);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", data); end
        checks++; if (recv !== 1'b0) begin errors++; $display("FAIL reset_recv: got %0b expected 0", recv); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %0b expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %0b expected 0", perr); end
        rst = 1'b0;
        tick(4);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_single();
        int t0;
        clear_logs();
        send_frame(1'b0, 8'hA5, ^8'hA5, 1'b1, 99, t0);
        tick(20);
        exp_data = 8'hA5;
        checks++; if (recv_ev.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", recv_ev.size()); end
        if (recv_ev.size() > 0) begin
            checks++; if (recv_ev[0].d !== 8'hA5) begin errors++; $display("FAIL single_data: got %0h expected a5", recv_ev[0].d); end
            checks++; if (recv_ev[0].t !== t0 + latency(CPB)) begin errors++; $display("FAIL single_time: got %0d expected %0d", recv_ev[0].t - t0, latency(CPB)); end
        end
        checks++; if (ferr_ev.size() + perr_ev.size() !== 0) begin errors++; $display("FAIL single_err: got %0d error strobes expected 0", ferr_ev.size() + perr_ev.size()); end
    endtask

    task automatic test_glitch();
        clear_logs();
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_mid: got %0b expected 1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop: got %0b expected 0", busy); end
        tick(200);
        checks++; if (recv_ev.size() + ferr_ev.size() + perr_ev.size() !== 0) begin errors++; $display("FAIL glitch_strobe: got %0d strobes expected 0", recv_ev.size() + ferr_ev.size() + perr_ev.size()); end
        checks++; if (data !== exp_data) begin errors++; $display("FAIL glitch_data: got %0h expected %0h", data, exp_data); end
    endtask

    task automatic test_frame_err();
        int t0;
        clear_logs();
        send_frame(1'b0, 8'h3C, ^8'h3C, 1'b0, 99, t0);
        tick(24);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy_held: got %0b expected 1", busy); end
        rx = 1'b1;
        tick(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy_sync: got %0b expected 1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL brk_busy_release: got %0b expected 0", busy); end
        tick(20);
        checks++; if (ferr_ev.size() !== 1) begin errors++; $display("FAIL brk_ferr_count: got %0d expected 1", ferr_ev.size()); end
        if (ferr_ev.size() > 0) begin
            checks++; if (ferr_ev[0] !== t0 + latency(CPB)) begin errors++; $display("FAIL brk_ferr_time: got %0d expected %0d", ferr_ev[0] - t0, latency(CPB)); end
        end
        checks++; if (recv_ev.size() + perr_ev.size() !== 0) begin errors++; $display("FAIL brk_other: got %0d strobes expected 0", recv_ev.size() + perr_ev.size()); end
        checks++; if (data !== exp_data) begin errors++; $display("FAIL brk_data: got %0h expected %0h", data, exp_data); end
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        clear_logs();
        send_frame(1'b0, 8'h00, ^8'h00, 1'b1, 99, t0);
        send_frame(1'b0, 8'hFF, ^8'hFF, 1'b1, 99, t1);
        tick(20);
        exp_data = 8'hFF;
        checks++; if (recv_ev.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", recv_ev.size()); end
        if (recv_ev.size() > 1) begin
            checks++; if (recv_ev[0].d !== 8'h00) begin errors++; $display("FAIL b2b_data0: got %0h expected 00", recv_ev[0].d); end
            checks++; if (recv_ev[1].d !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %0h expected ff", recv_ev[1].d); end
            checks++; if (recv_ev[1].t - recv_ev[0].t !== (10 + NPAR) * CPB) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", recv_ev[1].t - recv_ev[0].t, (10 + NPAR) * CPB); end
            checks++; if (recv_ev[0].t !== t0 + latency(CPB)) begin errors++; $display("FAIL b2b_time0: got %0d expected %0d", recv_ev[0].t - t0, latency(CPB)); end
        end
        checks++; if (data !== 8'hFF) begin errors++; $display("FAIL b2b_hold: got %0h expected ff", data); end
    endtask

    task automatic test_reset_mid();
        int t0, t1;
        clear_logs();
        send_frame(1'b0, 8'h55, ^8'h55, 1'b1, 4, t0);
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        exp_data = 8'h00;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %0h expected 00", data); end
        rst = 1'b0;
        tick(5);
        send_frame(1'b0, 8'h81, ^8'h81, 1'b1, 99, t1);
        tick(20);
        exp_data = 8'h81;
        checks++; if (recv_ev.size() !== 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", recv_ev.size()); end
        if (recv_ev.size() > 0) begin
            checks++; if (recv_ev[0].d !== 8'h81) begin errors++; $display("FAIL rstmid_newdata: got %0h expected 81", recv_ev[0].d); end
            checks++; if (recv_ev[0].t !== t1 + latency(CPB)) begin errors++; $display("FAIL rstmid_time: got %0d expected %0d", recv_ev[0].t - t1, latency(CPB)); end
        end
        checks++; if (ferr_ev.size() + perr_ev.size() !== 0) begin errors++; $display("FAIL rstmid_err: got %0d expected 0", ferr_ev.size() + perr_ev.size()); end
    endtask

    // Random bytes with random idle gaps (zero gap included); the model is a
    // queue of (expected arrival cycle, byte).
    task automatic test_random();
        int exp_t[$];
        logic [7:0] exp_b[$];
        int t0;
        logic [7:0] b;
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            send_frame(1'b0, b, ^b, 1'b1, 99, t0);
            exp_t.push_back(t0 + latency(CPB));
            exp_b.push_back(b);
            tick($urandom_range(0, 20));
        end
        tick(20);
        checks++; if (recv_ev.size() !== exp_b.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", recv_ev.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < recv_ev.size(); i++) begin
            checks++;
            if (recv_ev[i].d !== exp_b[i] || recv_ev[i].t !== exp_t[i]) begin
                errors++;
                $display("FAIL rand_frame%0d: got %0h@%0d expected %0h@%0d", i, recv_ev[i].d, recv_ev[i].t, exp_b[i], exp_t[i]);
            end
        end
        exp_data = exp_b[exp_b.size() - 1];
        checks++; if (data !== exp_data) begin errors++; $display("FAIL rand_hold: got %0h expected %0h", data, exp_data); end
    endtask

    task automatic test_cpb4();
        int t0;
        clear_logs();
        send_frame(1'b1, 8'hA5, ^8'hA5, 1'b1, 99, t0);
        tick(10);
        checks++; if (recv4_ev.size() !== 1) begin errors++; $display("FAIL cpb4_count: got %0d expected 1", recv4_ev.size()); end
        if (recv4_ev.size() > 0) begin
            checks++; if (recv4_ev[0].d !== 8'hA5) begin errors++; $display("FAIL cpb4_data: got %0h expected a5", recv4_ev[0].d); end
            checks++; if (recv4_ev[0].t !== t0 + latency(CPB4)) begin errors++; $display("FAIL cpb4_time: got %0d expected %0d", recv4_ev[0].t - t0, latency(CPB4)); end
        end
        checks++; if (other4_n !== 0) begin errors++; $display("FAIL cpb4_err: got %0d error strobes expected 0", other4_n); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int t0;
        clear_logs();
        send_frame(1'b0, 8'h07, 1'b0, 1'b1, 99, t0);
        tick(20);
        checks++; if (perr_ev.size() !== 1) begin errors++; $display("FAIL par_bad_count: got %0d expected 1", perr_ev.size()); end
        if (perr_ev.size() > 0) begin
            checks++; if (perr_ev[0] !== t0 + latency(CPB)) begin errors++; $display("FAIL par_bad_time: got %0d expected %0d", perr_ev[0] - t0, latency(CPB)); end
        end
        checks++; if (recv_ev.size() !== 0) begin errors++; $display("FAIL par_bad_recv: got %0d expected 0", recv_ev.size()); end
        checks++; if (data !== exp_data) begin errors++; $display("FAIL par_bad_data: got %0h expected %0h", data, exp_data); end
        clear_logs();
        send_frame(1'b0, 8'h07, 1'b1, 1'b1, 99, t0);
        tick(20);
        exp_data = 8'h07;
        checks++; if (recv_ev.size() !== 1 || perr_ev.size() !== 0) begin errors++; $display("FAIL par_good: got recv=%0d perr=%0d expected 1/0", recv_ev.size(), perr_ev.size()); end
        checks++; if (data !== 8'h07) begin errors++; $display("FAIL par_good_data: got %0h expected 07", data); end
        clear_logs();
        send_frame(1'b0, 8'h07, 1'b0, 1'b0, 99, t0);
        tick(8);
        rx = 1'b1;
        tick(20);
        checks++; if (ferr_ev.size() !== 1 || perr_ev.size() !== 0) begin errors++; $display("FAIL par_both: got ferr=%0d perr=%0d expected 1/0", ferr_ev.size(), perr_ev.size()); end
    endtask
`endif

    task automatic test_strobe_rules();
        checks++; if (viol !== 0) begin errors++; $display("FAIL strobe_rules: got %0d violations expected 0", viol); end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_cpb4();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_strobe_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
